// File: rtl/ecg_acc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ecg_acc_pkg : shared constants and loader FSM encoding             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ecg_acc_pkg;

    localparam int ECG_NUM_BANKS  = 4;
    localparam int ECG_BANK_IDX_W = $clog2(ECG_NUM_BANKS);
    localparam int ECG_DATA_DEPTH = 1024;
    localparam int ECG_FRAME_CAP  = ECG_NUM_BANKS * ECG_DATA_DEPTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_CS = 3'd1,
        S_HDR_HI  = 3'd2,
        S_HDR_LO  = 3'd3,
        S_DATA    = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } ldr_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave_rx : SPI mode-0 byte receiver, MSB first, clk-domain out |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_slave_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_sclk_i,
    input  logic             spi_cs_n_i,
    input  logic             spi_mosi_i,
    output logic [WIDTH-1:0] byte_o,
    output logic             byte_vld_o,
    output logic             cs_active_o
);

    logic [2:0]       sclk_q;
    logic [1:0]       cs_n_q;
    logic [1:0]       mosi_q;
    logic [2:0]       bit_cnt_q;
    logic [WIDTH-2:0] shift_q;
    logic             w_sclk_rise;
    logic             w_cs_act;

    assign w_sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign w_cs_act    = ~cs_n_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q    <= '0;
            cs_n_q    <= '0;
            mosi_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk_i};
            cs_n_q <= {cs_n_q[0], spi_cs_n_i};
            mosi_q <= {mosi_q[0], spi_mosi_i};
            if (!w_cs_act) begin
                bit_cnt_q <= '0;
            end else if (w_sclk_rise) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (w_cs_act && w_sclk_rise) begin
                shift_q <= {shift_q[WIDTH-3:0], mosi_q[1]};
            end
        end
    end

    // The final bit is taken straight from the synchronizer so the byte is
    // presented in the same cycle as the completing sclk edge.
    assign byte_o      = {shift_q, mosi_q[1]};
    assign byte_vld_o  = w_sclk_rise & w_cs_act & (bit_cnt_q == 3'd7);
    assign cs_active_o = w_cs_act;

endmodule
`default_nettype wire

// File: rtl/spi_bank_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_bank_loader : SPI frame loader into round-robin feature banks  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_bank_loader
    import ecg_acc_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = ECG_DATA_DEPTH,
    parameter int NUM_BANKS  = ECG_NUM_BANKS,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic [NUM_BANKS-1:0]  bank_csen,
    output logic                  bank_wrenb,
    output logic [ADDR_WIDTH-1:0] bank_addr,
    output logic [DATA_WIDTH-1:0] bank_data,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int                   BANK_IDX_W = $clog2(NUM_BANKS);
    localparam logic [CNT_WIDTH-1:0] FRAME_CAP  = CNT_WIDTH'(NUM_BANKS * DATA_DEPTH);

    logic [DATA_WIDTH-1:0] w_rx_byte;
    logic                  w_rx_vld;
    logic                  w_cs_act;
    logic                  w_cs_fall;
    logic [CNT_WIDTH-1:0]  w_hdr_count;
    logic [CNT_WIDTH-1:0]  w_idx_inc;

    ldr_state_e            state_q,  state_d;
    logic [CNT_WIDTH-1:0]  count_q,  count_d;
    logic [CNT_WIDTH-1:0]  idx_q,    idx_d;
    logic                  err_q,    err_d;
    logic                  cs_act_q;
    logic                  wr_q,     wr_d;
    logic [NUM_BANKS-1:0]  csen_q,   csen_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;

    spi_slave_rx #(
        .WIDTH       (DATA_WIDTH)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sclk_i  (spi_sclk),
        .spi_cs_n_i  (spi_cs_n),
        .spi_mosi_i  (spi_mosi),
        .byte_o      (w_rx_byte),
        .byte_vld_o  (w_rx_vld),
        .cs_active_o (w_cs_act)
    );

    assign w_cs_fall   = w_cs_act & ~cs_act_q;
    assign w_hdr_count = {count_q[CNT_WIDTH-1:DATA_WIDTH], w_rx_byte};
    assign w_idx_inc   = idx_q + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            cs_act_q <= 1'b0;
            wr_q     <= 1'b0;
            csen_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            cs_act_q <= w_cs_act;
            wr_q     <= wr_d;
            csen_q   <= csen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        err_d   = err_q;
        wr_d    = 1'b0;
        csen_d  = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_WAIT_CS;
                    err_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            S_WAIT_CS: begin
                if (w_cs_fall) begin
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (w_rx_vld) begin
                    count_d = {w_rx_byte, count_q[DATA_WIDTH-1:0]};
                    state_d = S_HDR_LO;
                end else if (!w_cs_act) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_HDR_LO: begin
                if (w_rx_vld) begin
                    count_d = w_hdr_count;
                    if (w_hdr_count == '0) begin
                        state_d = S_DONE;
                    end else if (w_hdr_count > FRAME_CAP) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (!w_cs_act) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_DATA: begin
                if (w_rx_vld) begin
                    // Low index bits pick the bank, the rest form the word address.
                    wr_d    = 1'b1;
                    csen_d  = NUM_BANKS'(1) << idx_q[BANK_IDX_W-1:0];
                    addr_d  = ADDR_WIDTH'(idx_q >> BANK_IDX_W);
                    wdata_d = w_rx_byte;
                    idx_d   = w_idx_inc;
                    if (w_idx_inc == count_q) begin
                        state_d = S_DONE;
                    end
                end else if (!w_cs_act) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bank_wrenb = wr_q;
    assign bank_csen  = csen_q;
    assign bank_addr  = addr_q;
    assign bank_data  = wdata_q;
    assign load_busy  = (state_q == S_WAIT_CS) || (state_q == S_HDR_HI) ||
                        (state_q == S_HDR_LO)  || (state_q == S_DATA);
    assign load_done  = (state_q == S_DONE);
    assign load_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_bank_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_bank_loader : self-checking bench for spi_bank_loader       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spi_bank_loader;

    localparam int NB    = 4;
    // Depth reduced so a full-capacity frame stays short in simulation.
    localparam int DEPTH = 64;
    localparam int CAP   = NB * DEPTH;
    localparam int AW    = 13;
    localparam int SH    = 50;

    typedef struct packed {
        logic [NB-1:0] csen;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          spi_sclk = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic [NB-1:0] bank_csen;
    logic          bank_wrenb;
    logic [AW-1:0] bank_addr;
    logic [7:0]    bank_data;
    logic          load_busy;
    logic          load_done;
    logic          load_err;

    int   n_checks = 0;
    int   n_pass   = 0;
    wr_t  wq[$];
    wr_t  exp_q[$];
    logic [7:0] tx_q[$];
    int   done_cnt   = 0;
    int   stray_csen = 0;
    int   wide_wr    = 0;
    logic prev_wr    = 1'b0;

    spi_bank_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (8),
        .DATA_DEPTH (DEPTH),
        .NUM_BANKS  (NB),
        .CNT_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .bank_csen  (bank_csen),
        .bank_wrenb (bank_wrenb),
        .bank_addr  (bank_addr),
        .bank_data  (bank_data),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (bank_wrenb === 1'b1) wq.push_back(wr_t'({bank_csen, bank_addr, bank_data}));
            else if (bank_csen !== '0) stray_csen++;
            if (bank_wrenb === 1'b1 && prev_wr === 1'b1) wide_wr++;
            prev_wr = bank_wrenb;
            if (load_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            #SH spi_sclk = 1'b1;
            #SH spi_sclk = 1'b0;
        end
    endtask

    task automatic arm();
        @(negedge clk) load_start = 1'b1;
        @(negedge clk) load_start = 1'b0;
    endtask

    task automatic clear_mon();
        wq.delete();
        done_cnt   = 0;
        stray_csen = 0;
        wide_wr    = 0;
    endtask

    task automatic send_frame(input logic [15:0] hdr, input int nsent, input int extra_bits);
        spi_cs_n = 1'b0;
        #(SH + 7);
        spi_bits(hdr[15:8], 8);
        spi_bits(hdr[7:0], 8);
        for (int i = 0; i < nsent; i++) spi_bits(tx_q[i], 8);
        if (extra_bits > 0) spi_bits(8'($urandom), extra_bits);
        #(SH + 7) spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    function automatic void build_expected(input int count, input int nsent);
        exp_q.delete();
        if (count >= 1 && count <= CAP) begin
            for (int i = 0; i < count && i < nsent; i++) begin
                wr_t w;
                w.csen = NB'(1) << (i % NB);
                w.addr = AW'(i / NB);
                w.data = tx_q[i];
                exp_q.push_back(w);
            end
        end
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= wq.size() || wq[i] !== exp_q[i]) return i;
        if (wq.size() > exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    function automatic wr_t got_at(input int i);
        if (i < wq.size()) return wq[i];
        return '0;
    endfunction

    function automatic wr_t exp_at(input int i);
        if (i < exp_q.size()) return exp_q[i];
        return '0;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bank_csen, bank_wrenb, bank_addr, bank_data, load_busy, load_done, load_err} !== '0)
            $display("FAIL reset_hold: outputs=%h required 0",
                     {bank_csen, bank_wrenb, bank_addr, bank_data, load_busy, load_done, load_err});
        else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({bank_csen, bank_wrenb, bank_addr, bank_data, load_busy, load_done, load_err} !== '0)
            $display("FAIL reset_idle: outputs=%h required 0",
                     {bank_csen, bank_wrenb, bank_addr, bank_data, load_busy, load_done, load_err});
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        int d;
        bit got;
        tx_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        clear_mon();
        arm();
        n_checks++;
        if (load_busy !== 1'b1) $display("FAIL basic_busy: load_busy=%b required 1", load_busy);
        else n_pass++;
        got = 1'b0;
        fork
            send_frame(16'h0006, 6, 0);
            begin
                for (int k = 0; k < 20000 && !got; k++) begin
                    @(negedge clk);
                    if (load_done === 1'b1) got = 1'b1;
                end
                // load_start coinciding with the DONE cycle must be ignored
                if (got) begin
                    load_start = 1'b1;
                    @(negedge clk) load_start = 1'b0;
                end
            end
        join
        build_expected(6, 6);
        d = first_diff();
        n_checks++;
        if (d != -1) $display("FAIL basic_writes: idx %0d got %h required %h (n=%0d/%0d)",
                              d, got_at(d), exp_at(d), wq.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL basic_done: pulses=%0d required 1", done_cnt);
        else n_pass++;
        n_checks++;
        if ({load_busy, load_err} !== 2'b00)
            $display("FAIL basic_status: busy/err=%b required 00", {load_busy, load_err});
        else n_pass++;
        n_checks++;
        if (stray_csen != 0 || wide_wr != 0)
            $display("FAIL basic_strobe: stray_csen=%0d wide=%0d required 0/0", stray_csen, wide_wr);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        tx_q.delete();
        clear_mon();
        arm();
        send_frame(16'h0000, 0, 0);
        n_checks++;
        if (wq.size() != 0 || done_cnt != 1)
            $display("FAIL zero_count: writes=%0d done=%0d required 0/1", wq.size(), done_cnt);
        else n_pass++;
        n_checks++;
        if ({load_busy, load_err} !== 2'b00)
            $display("FAIL zero_status: busy/err=%b required 00", {load_busy, load_err});
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] hdrs [2];
        hdrs[0] = 16'h1001;
        hdrs[1] = 16'(CAP + 1);
        for (int t = 0; t < 2; t++) begin
            tx_q = '{8'hAA, 8'h55};
            clear_mon();
            arm();
            n_checks++;
            if (load_err !== 1'b0) $display("FAIL ovf_err_clear: load_err=%b required 0", load_err);
            else n_pass++;
            send_frame(hdrs[t], 2, 0);
            n_checks++;
            if (load_err !== 1'b1 || wq.size() != 0 || done_cnt != 0 || load_busy !== 1'b0)
                $display("FAIL ovf_hdr_%h: err=%b writes=%0d done=%0d busy=%b required 1/0/0/0",
                         hdrs[t], load_err, wq.size(), done_cnt, load_busy);
            else n_pass++;
        end
    endtask

    task automatic test_early_release();
        int d;
        tx_q = '{8'hA5};
        clear_mon();
        arm();
        n_checks++;
        if (load_err !== 1'b0) $display("FAIL early_err_clear: load_err=%b required 0", load_err);
        else n_pass++;
        send_frame(16'h0004, 1, 3);
        build_expected(4, 1);
        d = first_diff();
        n_checks++;
        if (d != -1) $display("FAIL early_writes: idx %0d got %h required %h (n=%0d/%0d)",
                              d, got_at(d), exp_at(d), wq.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (load_err !== 1'b1 || done_cnt != 0 || load_busy !== 1'b0)
            $display("FAIL early_status: err=%b done=%0d busy=%b required 1/0/0",
                     load_err, done_cnt, load_busy);
        else n_pass++;
    endtask

    task automatic test_full_capacity();
        int d;
        tx_q.delete();
        for (int i = 0; i < CAP; i++) tx_q.push_back(8'(i));
        clear_mon();
        arm();
        send_frame(16'(CAP), CAP, 0);
        build_expected(CAP, CAP);
        d = first_diff();
        n_checks++;
        if (d != -1) $display("FAIL full_writes: idx %0d got %h required %h (n=%0d/%0d)",
                              d, got_at(d), exp_at(d), wq.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (got_at(CAP - 1) !== wr_t'({4'b1000, 13'(DEPTH - 1), 8'hFF}))
            $display("FAIL full_last: got %h required %h", got_at(CAP - 1),
                     wr_t'({4'b1000, 13'(DEPTH - 1), 8'hFF}));
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || load_err !== 1'b0 || stray_csen != 0 || wide_wr != 0)
            $display("FAIL full_status: done=%0d err=%b stray=%0d wide=%0d required 1/0/0/0",
                     done_cnt, load_err, stray_csen, wide_wr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d;
        for (int f = 0; f < 2; f++) begin
            tx_q.delete();
            for (int i = 0; i < 10; i++) tx_q.push_back(8'($urandom));
            clear_mon();
            arm();
            fork
                send_frame(16'd10, 10, 0);
                begin
                    // stray load_start while the frame is in flight
                    #(SH * 2 * 8 * 4);
                    @(negedge clk) load_start = 1'b1;
                    @(negedge clk) load_start = 1'b0;
                end
            join
            build_expected(10, 10);
            d = first_diff();
            n_checks++;
            if (d != -1 || done_cnt != 1)
                $display("FAIL b2b_frame%0d: idx %0d got %h required %h done=%0d",
                         f, d, got_at(d), exp_at(d), done_cnt);
            else n_pass++;
        end
        tx_q = '{8'h01, 8'h02, 8'h03};
        clear_mon();
        send_frame(16'h0003, 3, 0);
        n_checks++;
        if (wq.size() != 0 || done_cnt != 0 || load_busy !== 1'b0)
            $display("FAIL idle_traffic: writes=%0d done=%0d busy=%b required 0/0/0",
                     wq.size(), done_cnt, load_busy);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        int d, len, nsent, extra, mode;
        bit exp_done;
        for (int f = 0; f < 8; f++) begin
            mode  = int'($urandom_range(0, 2));
            len   = int'($urandom_range(1, 20));
            extra = 0;
            if (mode == 0) nsent = len;
            else if (mode == 1) nsent = len + int'($urandom_range(1, 3));
            else begin
                nsent = int'($urandom_range(0, len - 1));
                extra = int'($urandom_range(0, 7));
            end
            tx_q.delete();
            for (int i = 0; i < nsent; i++) tx_q.push_back(8'($urandom));
            clear_mon();
            arm();
            send_frame(16'(len), nsent, extra);
            build_expected(len, nsent);
            exp_done = (nsent >= len);
            d = first_diff();
            n_checks++;
            if (d != -1) $display("FAIL rand%0d_writes: len=%0d sent=%0d idx %0d got %h required %h",
                                  f, len, nsent, d, got_at(d), exp_at(d));
            else n_pass++;
            n_checks++;
            if (done_cnt != int'(exp_done) || load_err !== !exp_done)
                $display("FAIL rand%0d_status: done=%0d err=%b required %0d/%b",
                         f, done_cnt, load_err, exp_done, !exp_done);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int d;
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
        clear_mon();
        arm();
        spi_cs_n = 1'b0;
        #(SH + 7);
        spi_bits(8'h00, 8);
        spi_bits(8'h08, 8);
        for (int i = 0; i < 3; i++) spi_bits(tx_q[i], 8);
        n_checks++;
        if (load_busy !== 1'b1) $display("FAIL midrst_busy_before: load_busy=%b required 1", load_busy);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bank_csen, bank_wrenb, bank_addr, bank_data, load_busy, load_done, load_err} !== '0)
            $display("FAIL midrst_outputs: outputs=%h required 0",
                     {bank_csen, bank_wrenb, bank_addr, bank_data, load_busy, load_done, load_err});
        else n_pass++;
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
        clear_mon();
        arm();
        send_frame(16'h0008, 8, 0);
        build_expected(8, 8);
        d = first_diff();
        n_checks++;
        if (d != -1 || done_cnt != 1)
            $display("FAIL midrst_reload: idx %0d got %h required %h done=%0d",
                     d, got_at(d), exp_at(d), done_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_zero_count();
        test_overflow();
        test_early_release();
        test_full_capacity();
        test_back_to_back();
        test_random_frames();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
